// File: rtl/rx_decim_comb.sv
// rx_decim_comb: receive-side polyphase decimating comb filter.
// Sums each block of DECIM accepted samples into B and runs the block sums
// through the symmetric 3-tap kernel [COFF1, COFF2, COFF1] in transposed
// form. One full-precision output strobe is produced per completed block.
module rx_decim_comb #(
  parameter int DECIM = 4,
  parameter int COFF1 = 84,
  parameter int COFF2 = 344
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic signed [10:0] in_dec,
  output logic               out_valid,
  output logic signed [25:0] out_dec,
  output logic               out_phase_err
);

  // Kernel coefficients at the output word width; products are kept at
  // 26 bits because the parameter limits bound every result below 2^25.
  localparam logic signed [25:0] K1      = 26'(COFF1);
  localparam logic signed [25:0] K2      = 26'(COFF2);
  localparam logic        [2:0]  PH_LAST = 3'(DECIM - 1);

  // Sign-extend an 11-bit sample to the 14-bit accumulator width.
  function automatic logic signed [13:0] sext_sample(input logic signed [10:0] s);
    return {{3{s[10]}}, s};
  endfunction

  // Sign-extend a 14-bit block sum to the 26-bit product width.
  function automatic logic signed [25:0] sext_block(input logic signed [13:0] b);
    return {{12{b[13]}}, b};
  endfunction

  logic        [2:0]  ph_r;
  logic signed [13:0] acc_r;
  logic signed [25:0] s1_r;
  logic signed [25:0] s2_r;

  logic signed [13:0] in_ext_s;
  logic signed [13:0] blk_sum_s;
  logic signed [25:0] blk_wide_s;
  logic signed [25:0] prod1_s;
  logic signed [25:0] prod2_s;
  logic signed [13:0] acc_nxt_s;
  logic               last_s;

  // Block sum, kernel products and next accumulator value for this sample.
  always_comb begin
    in_ext_s   = sext_sample(in_dec);
    blk_sum_s  = acc_r + in_ext_s;
    blk_wide_s = sext_block(blk_sum_s);
    prod1_s    = K1 * blk_wide_s;
    prod2_s    = K2 * blk_wide_s;
    last_s     = (ph_r == PH_LAST);
    if (ph_r == 3'd0) begin
      acc_nxt_s = in_ext_s;
    end else begin
      acc_nxt_s = blk_sum_s;
    end
  end

  // Phase counter, block accumulator, transposed kernel state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_r          <= 3'd0;
      acc_r         <= 14'sd0;
      s1_r          <= 26'sd0;
      s2_r          <= 26'sd0;
      out_dec       <= 26'sd0;
      out_valid     <= 1'b0;
      out_phase_err <= 1'b0;
    end else if (clear) begin
      // Flush drops any sample presented this cycle; a flush that lands
      // inside a block is remembered until the next reset.
      ph_r      <= 3'd0;
      acc_r     <= 14'sd0;
      s1_r      <= 26'sd0;
      s2_r      <= 26'sd0;
      out_valid <= 1'b0;
      if (ph_r != 3'd0) begin
        out_phase_err <= 1'b1;
      end else begin
        out_phase_err <= out_phase_err;
      end
    end else if (in_valid) begin
      if (last_s) begin
        ph_r      <= 3'd0;
        acc_r     <= 14'sd0;
        s1_r      <= prod1_s;
        s2_r      <= s1_r + prod2_s;
        out_dec   <= s2_r + prod1_s;
        out_valid <= 1'b1;
      end else begin
        ph_r      <= ph_r + 3'd1;
        acc_r     <= acc_nxt_s;
        out_valid <= 1'b0;
      end
    end else begin
      // Gap: all state holds, only the strobe drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_decim_comb.sv
// Self-checking bench for rx_decim_comb with DECIM=4, COFF1=84, COFF2=344.
// The reference model treats the filter as a plain FIR over block sums.
module tb_rx_decim_comb;

  localparam int DECIM = 4;
  localparam int C1    = 84;
  localparam int C2    = 344;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [10:0] in_dec = 11'sd0;
  logic               out_valid;
  logic signed [25:0] out_dec;
  logic               out_phase_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: running block sum, samples in block, last two
  // block sums, expected outputs.
  int m_sum, m_cnt, m_b1, m_b2, m_dec;
  bit m_valid, m_err;

  rx_decim_comb #(.DECIM(DECIM), .COFF1(C1), .COFF2(C2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_dec(in_dec),
    .out_valid(out_valid), .out_dec(out_dec), .out_phase_err(out_phase_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_b1 = 0; m_b2 = 0; m_dec = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(input bit clr, input bit v, input int d);
    if (clr) begin
      if (m_cnt != 0) m_err = 1;
      m_cnt = 0; m_sum = 0; m_b1 = 0; m_b2 = 0; m_valid = 0;
    end else if (v) begin
      m_sum += d;
      m_cnt++;
      if (m_cnt == DECIM) begin
        m_dec = C1 * m_sum + C2 * m_b1 + C1 * m_b2;
        m_b2 = m_b1; m_b1 = m_sum; m_sum = 0; m_cnt = 0; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end else begin
      m_valid = 0;
    end
  endtask

  // Present one cycle of input, advance the model, settle after the edge.
  task automatic drive(input bit clr, input bit v, input int d);
    @(negedge clk);
    clear = clr; in_valid = v; in_dec = d[10:0];
    model_step(clr, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_dec = 11'sd0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b1; in_valid = 1'b1; in_dec = 11'sd5;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_dec !== 26'sd0 || out_phase_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%0b dec=%0d err=%0b, expected 0 0 0", out_valid, out_dec, out_phase_err);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_dec !== 26'sd0 || out_phase_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_with_clear: valid=%0b dec=%0d err=%0b, expected 0 0 0", out_valid, out_dec, out_phase_err);
    end
    @(negedge clk);
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_impulse();
    int vals[$];
    int cyc[$];
    int exp_v[4] = '{84, 344, 84, 0};
    int exp_c[4] = '{3, 7, 11, 15};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, (i == 0) ? 1 : 0);
      checks++;
      if (out_valid !== m_valid || out_dec !== 26'(m_dec)) begin
        errors++;
        $display("FAIL impulse_cycle %0d: valid=%0b dec=%0d, expected %0b %0d", i, out_valid, out_dec, m_valid, m_dec);
      end
      if (out_valid === 1'b1) begin vals.push_back(int'(out_dec)); cyc.push_back(i); end
    end
    drive(1'b0, 1'b0, 0);
    checks++;
    if (vals.size() != 4) begin
      errors++;
      $display("FAIL impulse_count: got %0d strobes, expected 4", vals.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (vals[k] != exp_v[k] || cyc[k] != exp_c[k]) begin
          errors++;
          $display("FAIL impulse_strobe %0d: dec=%0d at sample %0d, expected %0d at sample %0d", k, vals[k], cyc[k], exp_v[k], exp_c[k]);
        end
      end
    end
  endtask

  task automatic test_dc(input int level, input int w0, input int w1, input int steady);
    int n = 0;
    int expv;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, level);
      checks++;
      if (out_valid !== m_valid || out_dec !== 26'(m_dec)) begin
        errors++;
        $display("FAIL dc_cycle %0d: valid=%0b dec=%0d, expected %0b %0d", i, out_valid, out_dec, m_valid, m_dec);
      end
      if (out_valid === 1'b1) begin
        expv = (n == 0) ? w0 : (n == 1) ? w1 : steady;
        checks++;
        if (out_dec !== 26'(expv)) begin
          errors++;
          $display("FAIL dc_strobe %0d: dec=%0d, expected %0d", n, out_dec, expv);
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL dc_count: got %0d strobes, expected 10", n);
    end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_gapped();
    int vals[$];
    int exp_v[4] = '{84, 344, 84, 0};
    int k = 0;
    bit v;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      v = (i % 3 == 0);
      drive(1'b0, v, (v && k == 0) ? 1 : 0);
      checks++;
      if (out_valid !== m_valid || out_dec !== 26'(m_dec)) begin
        errors++;
        $display("FAIL gapped_cycle %0d: valid=%0b dec=%0d, expected %0b %0d", i, out_valid, out_dec, m_valid, m_dec);
      end
      if (out_valid === 1'b1) begin
        vals.push_back(int'(out_dec));
        checks++;
        if (!(v && (k % 4 == 3))) begin
          errors++;
          $display("FAIL gapped_timing: strobe at cycle %0d, expected only after 4th accepted sample", i);
        end
      end
      if (v) k++;
    end
    checks++;
    if (vals.size() != 4) begin
      errors++;
      $display("FAIL gapped_count: got %0d strobes, expected 4", vals.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (vals[j] != exp_v[j]) begin
          errors++;
          $display("FAIL gapped_value %0d: dec=%0d, expected %0d", j, vals[j], exp_v[j]);
        end
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 5);
    drive(1'b1, 1'b1, 5);
    checks++;
    if (out_phase_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_at_phase0: err=%0b valid=%0b, expected 0 0", out_phase_err, out_valid);
    end
    drive(1'b0, 1'b1, 5);
    drive(1'b0, 1'b1, 5);
    drive(1'b1, 1'b1, 5);
    checks++;
    if (out_phase_err !== 1'b1 || out_valid !== 1'b0 || out_dec !== 26'(m_dec)) begin
      errors++;
      $display("FAIL clear_mid_block: err=%0b valid=%0b dec=%0d, expected 1 0 %0d", out_phase_err, out_valid, out_dec, m_dec);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5);
      checks++;
      if (out_valid !== m_valid || out_dec !== 26'(m_dec) || out_phase_err !== 1'b1) begin
        errors++;
        $display("FAIL clear_after %0d: valid=%0b dec=%0d err=%0b, expected %0b %0d 1", i, out_valid, out_dec, out_phase_err, m_valid, m_dec);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_dec !== 26'sd1680) begin
      errors++;
      $display("FAIL clear_restart: valid=%0b dec=%0d, expected 1 1680", out_valid, out_dec);
    end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int exp_v[3] = '{343728, 1751376, 2095104};
    do_reset();
    // Two strobes (8 samples) plus half a block.
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1023);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_dec !== 26'sd0 || out_phase_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b dec=%0d err=%0b, expected 0 0 0", out_valid, out_dec, out_phase_err);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1023);
      if (out_valid === 1'b1) begin
        checks++;
        if (n > 2 || out_dec !== 26'(exp_v[n])) begin
          errors++;
          $display("FAIL reset_mid_warmup %0d: dec=%0d, expected %0d", n, out_dec, (n < 3) ? exp_v[n] : 0);
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d strobes, expected 3", n);
    end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    bit c, v;
    int d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 9) < 7);
      d = int'($urandom_range(0, 2047)) - 1024;
      drive(c, v, d);
      checks++;
      if (out_valid !== m_valid || out_dec !== 26'(m_dec) || out_phase_err !== m_err) begin
        errors++;
        $display("FAIL random_cycle %0d: valid=%0b dec=%0d err=%0b, expected %0b %0d %0b", i, out_valid, out_dec, out_phase_err, m_valid, m_dec, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_dc(1023, 343728, 1751376, 2095104);
    test_dc(-1024, -344064, -1753088, -2097152);
    test_gapped();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_decim_comb.md
# rx_decim_comb

Receive-side polyphase decimating comb filter: the counterpart of the transmit interpolation comb branches. It accepts a strobed stream of signed 11-bit samples and decimates by `DECIM`. It sums each block of `DECIM` samples and applies the symmetric 3-tap block kernel [COFF1, COFF2, COFF1] in transposed form. It emits one full-precision output per block with a one-cycle valid strobe, feeding the Rx demapper/AGC path.

## Interface
- `DECIM`, 4: decimation factor. Legal range 2..8.
- `COFF1`, 84: outer kernel coefficient. Signed, |COFF1| ≤ 511.
- `COFF2`, 344: centre kernel coefficient. Signed, |COFF2| ≤ 511.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush of phase counter and filter history.
- `in_valid`  in  1  qualifies `in_dec` this cycle.
- `in_dec`  in  11  signed input sample.
- `out_valid`  out  1  one-cycle strobe marking a new `out_dec`.
- `out_dec`  out  26  signed filtered, decimated output. Held between strobes.
- `out_phase_err`  out  1  sticky flag; set if `clear` arrives mid-block (phase ≠ 0).

## Operation
- Phase counter `ph`, 0..DECIM-1, advances only on accepted samples (`in_valid`=1). It wraps to 0 after DECIM-1.
- Block accumulator `acc`, 14-bit signed. The first sample of a block (`ph`=0) loads `acc <= in_dec`; other samples do `acc <= acc + in_dec`.
- Block sum `B = acc + in_dec` (or `in_dec` alone when DECIM… never; `ph`=DECIM-1 ≥ 1) is formed combinationally on the sample where `ph`=DECIM-1.
- On that completing sample, transposed kernel update, all in one edge:
  - `s1 <= COFF1*B`
  - `s2 <= s1 + COFF2*B`
  - `out_dec <= s2 + COFF1*B`
  - `out_valid <= 1`
- Resulting output: y[m] = COFF1·B[m] + COFF2·B[m-1] + COFF1·B[m-2].
- `s1`/`s2` are 26-bit signed. All arithmetic is sign-extended full precision: no rounding, no saturation. Range is guaranteed by the parameter limits: |B| ≤ 8192, |y| ≤ 2·511·8192 + 511·8192 < 2^25.
- `out_valid` is 0 on every cycle without a completing sample.
- `out_dec` holds its last value until the next strobe.
- Warm-up: the first two outputs after reset/clear use zero history for B[m-1] and B[m-2]. The third output is the first fully valid one.
- `clear` (synchronous, priority over `in_valid`):
  - Zeroes `ph`, `acc`, `s1`, `s2`.
  - Forces `out_valid` to 0; `out_dec` is held.
  - Any sample presented in the same cycle is dropped.
  - If `ph`≠0, sets `out_phase_err`. Only `rst` clears `out_phase_err`.
- `in_valid` gaps of any length are allowed; state holds unchanged during gaps.

## Timing
- Reset values (asynchronous, while `rst`=1): `ph`=0, `acc`=0, `s1`=0, `s2`=0, `out_dec`=0, `out_valid`=0, `out_phase_err`=0.
- Reset mid-block discards the partial block. The first sample after deassertion starts phase 0.
- Latency: `out_valid`/`out_dec` update at the same rising edge that accepts the block's last sample, i.e. visible one cycle after that sample is presented.
- Maximum throughput: one sample per cycle, giving one output every DECIM cycles.
- `clear` and `rst` asserted together: `rst` wins.

## Test plan
All scenarios use DECIM=4, COFF1=84, COFF2=344.
- **Impulse:** `in_dec`=1 then 15 zeros, continuous valid → four strobes with `out_dec` = 84, 344, 84, 0. Strobes fall every 4th cycle, one cycle after samples 3, 7, 11, 15.
- **Positive DC:** 40 samples of 1023 → B=4092; steady-state `out_dec`=2095104 from the 3rd strobe on. Warm-up strobes are 343728 and 1751376.
- **Negative full scale:** 40 samples of -1024 → steady `out_dec`=-2097152. No wrap in the sign bits.
- **Gapped input:** the impulse scenario with `in_valid` toggling 1,0,0,1,… → identical output values. Strobes occur only after the 4th accepted sample of each block.
- **Clear mid-block:** `clear` after 2 accepted samples of 5 → `out_phase_err`=1 and no strobe. The next 4 samples of 5 produce `out_dec`=1680 (84·20). `clear` at `ph`=0 leaves the flag 0.
- **Reset mid-operation:** assert `rst` between the 2nd and 3rd strobe of the DC test → all outputs 0 immediately. After release, the warm-up sequence repeats exactly.
